// File: rtl/mod_counter_pkg.sv
// Shared definitions for the cascaded modulo counter.
// Contents:
//   DIR_UP / DIR_DOWN : encodings of the Up input
//   clamp_digit       : limits a loaded digit value to the legal range 0..k-1
package mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // A loaded value outside the digit's modulus would put the digit in a state
  // it can never reach by counting, so it is pinned to the largest legal value.
  function automatic int unsigned clamp_digit(input int unsigned value,
                                              input int unsigned k);
    return (value >= k) ? (k - 1) : value;
  endfunction

endpackage

// File: rtl/mod_counter_cascade_if.sv
// Control and status bundle of mod_counter_cascade.
// Signals:
//   En, Up, Clear, Load : count enable, direction, synchronous clear, parallel load
//   LoadVal             : DIGITS*N packed load value, digit i at [i*N +: N]
//   Q                   : DIGITS*N packed count value, same packing
//   digit_tc            : per-digit wrap flag, one cycle, registered
//   rollover            : whole-counter wrap flag, one cycle, registered
// Modports: master drives the controls, slave is the counter itself.
interface mod_counter_cascade_if #(
  parameter int N      = 4,
  parameter int DIGITS = 2
);

  logic                  En;
  logic                  Up;
  logic                  Clear;
  logic                  Load;
  logic [DIGITS*N-1:0]   LoadVal;
  logic [DIGITS*N-1:0]   Q;
  logic [DIGITS-1:0]     digit_tc;
  logic                  rollover;

  modport master (
    output En, Up, Clear, Load, LoadVal,
    input  Q, digit_tc, rollover
  );

  modport slave (
    input  En, Up, Clear, Load, LoadVal,
    output Q, digit_tc, rollover
  );

endinterface

// File: rtl/mod_digit.sv
// One mod-K digit of the cascade, counting in an N-bit field.
// Ports:
//   Clock, Reset_n : rising-edge clock, asynchronous active-low reset
//   en             : count enable for this digit (already gated by lower digits)
//   Up             : direction, DIR_UP counts up
//   Clear, Load    : synchronous clear / parallel load, Clear has priority
//   load_val       : value for Load, clamped to K-1
//   q              : current digit value
//   at_term        : combinational, digit sits at its terminal value for Up
//   wrap           : registered, digit wrapped on the previous edge
module mod_digit
  import mod_counter_pkg::*;
#(
  parameter int N = 4,
  parameter int K = 10
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         en,
  input  logic         Up,
  input  logic         Clear,
  input  logic         Load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] q,
  output logic         at_term,
  output logic         wrap
);

  // K-1 held at N+1 bits so K = 2**N compares without overflow.
  localparam logic [N:0] K_MAX = (N+1)'(K - 1);

  logic [N-1:0] q_d, q_q;
  logic         wrap_d, wrap_q;

  always_comb begin
    if (Up == DIR_UP) at_term = ({1'b0, q_q} == K_MAX);
    else              at_term = (q_q == '0);
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (Clear) begin
      q_d = '0;
    end else if (Load) begin
      q_d = N'(clamp_digit(32'(load_val), K));
    end else if (en) begin
      if (at_term) begin
        // Wrapping flips to the opposite end of the range.
        wrap_d = 1'b1;
        q_d    = (Up == DIR_UP) ? '0 : K_MAX[N-1:0];
      end else begin
        q_d = (Up == DIR_UP) ? (q_q + N'(1)) : (q_q - N'(1));
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/mod_counter_cascade.sv
// Multi-digit modulo counter: DIGITS cascaded mod-K digits of N bits each.
// Ports:
//   Clock   : rising-edge clock
//   Reset_n : asynchronous active-low reset
//   bus     : slave side of mod_counter_cascade_if (controls in, count/flags out)
// A carry ripples through every digit within one edge; digit_tc and rollover
// are the registered wrap flags of the digits and of the top digit.
module mod_counter_cascade
  import mod_counter_pkg::*;
#(
  parameter int N      = 4,
  parameter int K      = 10,
  parameter int DIGITS = 2
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  mod_counter_cascade_if.slave   bus
);

  if (K < 2 || K > (1 << N) || DIGITS < 1) begin : g_bad_params
    $error("mod_counter_cascade: illegal parameters N=%0d K=%0d DIGITS=%0d",
           N, K, DIGITS);
  end

  logic [DIGITS-1:0]   en_chain;
  logic [DIGITS-1:0]   at_term;
  logic [DIGITS-1:0]   wrap;
  logic [DIGITS*N-1:0] q_pack;

  // A digit advances only when every lower digit is at its terminal value,
  // judged on the pre-edge count and the current direction.
  always_comb begin
    en_chain[0] = bus.En;
    for (int i = 1; i < DIGITS; i++) begin
      en_chain[i] = en_chain[i-1] & at_term[i-1];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    mod_digit #(
      .N(N),
      .K(K)
    ) u_digit (
      .Clock    (Clock),
      .Reset_n  (Reset_n),
      .en       (en_chain[g]),
      .Up       (bus.Up),
      .Clear    (bus.Clear),
      .Load     (bus.Load),
      .load_val (bus.LoadVal[g*N +: N]),
      .q        (q_pack[g*N +: N]),
      .at_term  (at_term[g]),
      .wrap     (wrap[g])
    );
  end

  assign bus.Q        = q_pack;
  assign bus.digit_tc = wrap;
  assign bus.rollover = wrap[DIGITS-1];

endmodule

// File: tb/tb_mod_counter_cascade.sv
// Bench for mod_counter_cascade: a BCD-style 2x mod-10 counter and a 3x mod-8
// counter (K = 2**N) driven by the same controls, compared against an
// arithmetic model that treats each counter as one integer modulo K**DIGITS.
module tb_mod_counter_cascade;

  localparam int NA = 4, KA = 10, DA = 2;
  localparam int NB = 3, KB = 8,  DB = 3;

  logic Clock   = 1'b0;
  logic Reset_n = 1'b0;

  logic              en, up, clr, ld;
  logic [DA*NA-1:0]  ldA;
  logic [DB*NB-1:0]  ldB;

  int checkCount = 0;
  int failCount  = 0;

  int vA = 0, vB = 0, tcA = 0, tcB = 0;

  mod_counter_cascade_if #(.N(NA), .DIGITS(DA)) busA();
  mod_counter_cascade_if #(.N(NB), .DIGITS(DB)) busB();

  assign busA.En = en;  assign busA.Up = up;  assign busA.Clear = clr;
  assign busA.Load = ld;  assign busA.LoadVal = ldA;
  assign busB.En = en;  assign busB.Up = up;  assign busB.Clear = clr;
  assign busB.Load = ld;  assign busB.LoadVal = ldB;

  mod_counter_cascade #(.N(NA), .K(KA), .DIGITS(DA)) dutA (
    .Clock(Clock), .Reset_n(Reset_n), .bus(busA.slave)
  );

  mod_counter_cascade #(.N(NB), .K(KB), .DIGITS(DB)) dutB (
    .Clock(Clock), .Reset_n(Reset_n), .bus(busB.slave)
  );

  always #5 Clock = ~Clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int powInt(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r *= b;
    return r;
  endfunction

  // Integer value -> packed digit fields.
  function automatic int packQ(input int v, input int k, input int d, input int n);
    int r = 0;
    for (int i = 0; i < d; i++) begin
      r |= (v % k) << (i * n);
      v /= k;
    end
    return r;
  endfunction

  // Packed load value -> integer value, each digit limited to k-1.
  function automatic int unpackLoad(input int ldv, input int k, input int d, input int n);
    int r = 0;
    int p = 1;
    int dig;
    for (int i = 0; i < d; i++) begin
      dig = (ldv >> (i * n)) & ((1 << n) - 1);
      if (dig >= k) dig = k - 1;
      r += dig * p;
      p *= k;
    end
    return r;
  endfunction

  // One edge of the model. Digit i wraps exactly when the low i+1 digits
  // as a number pass through a multiple of k**(i+1).
  task automatic modelStep(inout int v, output int tc, input int k, input int d,
                           input int n, input int ldv);
    int m;
    m  = powInt(k, d);
    tc = 0;
    if (clr) begin
      v = 0;
    end else if (ld) begin
      v = unpackLoad(ldv, k, d, n);
    end else if (en) begin
      for (int i = 0; i < d; i++) begin
        if (up ? (((v + 1) % powInt(k, i + 1)) == 0) : ((v % powInt(k, i + 1)) == 0))
          tc |= (1 << i);
      end
      v = up ? ((v + 1) % m) : ((v + m - 1) % m);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic u, input logic c, input logic l,
                               input logic [DA*NA-1:0] la, input logic [DB*NB-1:0] lb);
    en = e; up = u; clr = c; ld = l; ldA = la; ldB = lb;
  endtask

  // Advance one edge, update the model with the pre-edge controls, compare.
  task automatic stepAndCheck(input string tag);
    @(posedge Clock);
    #1;
    modelStep(vA, tcA, KA, DA, NA, int'(ldA));
    modelStep(vB, tcB, KB, DB, NB, int'(ldB));
    checkOutput({tag, ".qA"},    int'(busA.Q),        packQ(vA, KA, DA, NA));
    checkOutput({tag, ".tcA"},   int'(busA.digit_tc), tcA);
    checkOutput({tag, ".rollA"}, int'(busA.rollover), (tcA >> (DA - 1)) & 1);
    checkOutput({tag, ".qB"},    int'(busB.Q),        packQ(vB, KB, DB, NB));
    checkOutput({tag, ".tcB"},   int'(busB.digit_tc), tcB);
    checkOutput({tag, ".rollB"}, int'(busB.rollover), (tcB >> (DB - 1)) & 1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".qA"},    int'(busA.Q), 0);
    checkOutput({tag, ".tcA"},   int'(busA.digit_tc), 0);
    checkOutput({tag, ".rollA"}, int'(busA.rollover), 0);
    checkOutput({tag, ".qB"},    int'(busB.Q), 0);
    checkOutput({tag, ".tcB"},   int'(busB.digit_tc), 0);
    checkOutput({tag, ".rollB"}, int'(busB.rollover), 0);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    #12;
    checkResetValues("reset");
    Reset_n = 1'b1;

    // Full up-count through all 100 BCD states and back to zero.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 100; i++) stepAndCheck("upRun");
    checkOutput("fullWrap.q",    int'(busA.Q), 'h00);
    checkOutput("fullWrap.roll", int'(busA.rollover), 1);

    // Load zero, then count down across the whole-counter boundary.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 9'h000);
    stepAndCheck("ld00");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    stepAndCheck("down1");
    checkOutput("down1.q",    int'(busA.Q), 'h99);
    checkOutput("down1.tc",   int'(busA.digit_tc), 3);
    checkOutput("down1.roll", int'(busA.rollover), 1);
    stepAndCheck("down2");
    checkOutput("down2.q",    int'(busA.Q), 'h98);
    checkOutput("down2.roll", int'(busA.rollover), 0);

    // Clamped load of an out-of-range low digit.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h5F, 9'h0AB);
    stepAndCheck("ld5F");
    checkOutput("clamp.q", int'(busA.Q), 'h59);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) stepAndCheck("afterClamp");
    checkOutput("afterClamp.q", int'(busA.Q), 'h62);

    // Clear beats Load; then idle with En low.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h37, 9'h123);
    stepAndCheck("ld37");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h37, 9'h123);
    stepAndCheck("clrLd");
    checkOutput("clrLd.q", int'(busA.Q), 'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++) stepAndCheck("idle");
    checkOutput("idle.roll", int'(busA.rollover), 0);

    // Asynchronous reset between edges with a load pending.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h42, 9'h042);
    stepAndCheck("ld42");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 9'h011);
    #2 Reset_n = 1'b0;
    #1;
    vA = 0; vB = 0;
    checkResetValues("asyncRst");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    #1 Reset_n = 1'b1;
    stepAndCheck("postRst");
    checkOutput("postRst.q", int'(busA.Q), 'h01);

    // K = 2**N wrap on the 3-digit octal counter.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 9'h1FF);
    stepAndCheck("ld777");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    stepAndCheck("octWrap");
    checkOutput("octWrap.q",    int'(busB.Q), 0);
    checkOutput("octWrap.tc",   int'(busB.digit_tc), 7);
    checkOutput("octWrap.roll", int'(busB.rollover), 1);

    // Random mix of enable, direction, clear and load.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 9) != 0),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 39) == 0),
                    1'($urandom_range(0, 24) == 0),
                    8'($urandom), 9'($urandom));
      stepAndCheck("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mod_counter_cascade.md
Name: mod_counter_cascade

Overview:
- Parametrised multi-digit modulo counter. DIGITS cascaded digits, each counting modulo K in an N-bit field.
- Each digit is a generalised mod-k counter with up/down direction, enable, synchronous clear and parallel load.
- Produces per-digit carry/borrow flags and a whole-counter rollover pulse.
- Serves as the timebase and event-count block for display and timer datapaths, e.g. BCD seconds/minutes with K=10.

Parameters:
- N, 4, bit width of one digit field
- K, 10, modulus of each digit; legal range 2 <= K <= 2**N
- DIGITS, 2, number of cascaded digits; DIGITS >= 1

Ports:
- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- En  in  1  count enable for digit 0 (least significant)
- Up  in  1  direction: 1 = count up, 0 = count down
- Clear  in  1  synchronous clear of all digits
- Load  in  1  synchronous parallel load
- LoadVal  in  DIGITS*N  load value; digit i in bits [i*N+N-1 : i*N]
- Q  out  DIGITS*N  count value, same digit packing as LoadVal
- digit_tc  out  DIGITS  per-digit terminal flag, registered
- rollover  out  1  whole-counter wrap flag, registered, one-cycle pulse

Behaviour:
- Interface (already decided): one clock, Clock. Reset_n is asynchronous and active-low.
- Reset (Reset_n=0): Q=0, digit_tc=0, rollover=0, applied immediately regardless of Clock. These values hold until the first rising edge after Reset_n returns to 1.
- Priority at each rising edge: Clear > Load > count > hold.
- Clear=1: Q=0, digit_tc=0, rollover=0.
- Load=1 (Clear=0): each digit takes min(LoadVal digit, K-1); values >= K clamp to K-1. digit_tc=0, rollover=0.
- Terminal value of a digit: K-1 when Up=1, 0 when Up=0.
- Digit enable chain (combinational):
  - en[0] = En.
  - en[i] = en[i-1] AND (digit i-1 at terminal value).
  - All terminal tests use the pre-edge Q and the current Up.
- Enabled digit, Up=1: Q_i = K-1 ? 0 : Q_i+1.
- Enabled digit, Up=0: Q_i = 0 ? K-1 : Q_i-1.
- Disabled digit holds its value.
- digit_tc[i] is 1 for exactly one cycle after an edge at which digit i wrapped (K-1->0 up, or 0->K-1 down); otherwise 0. It is coincident with Q showing the wrapped value.
- rollover = 1 for the one cycle following an edge where digit DIGITS-1 wrapped, i.e. the whole counter went max->0 or 0->max. Otherwise 0.
- Latency: Q updates on the edge at which En is sampled; there is no pipeline. A carry ripples through all digits in the same edge.
- Up may change on any cycle; the new direction applies at the next edge. No hold or flush is required on a direction change.
- En=0 with Clear=0 and Load=0: Q holds, digit_tc=0, rollover=0.
- Reset asserted mid-count or mid-load: the outputs go to reset values asynchronously, and any pending Load or Clear is discarded.
- Arithmetic: each digit is computed in N bits. K=2**N must wrap correctly with no overflow glitch; compare against K-1 at N+1 bits if needed.
- Elaboration-time check: flag an error if K < 2, K > 2**N, or DIGITS < 1.

Decomposition:
- Shared package mod_counter_pkg holds:
  - the direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0;
  - a function clamp_digit(value, K).
- Sub-module mod_digit (N, K): one digit.
  - Inputs: Clock, Reset_n, en, Up, Clear, Load, load_val.
  - Outputs: q, at_term (combinational terminal test), wrap (registered).
- The top level generates DIGITS instances, builds the en chain, packs Q, and drives rollover from the top digit's wrap.

Test Plan:
- N=4, K=10, DIGITS=2, En=1, Up=1 from reset:
  - Q steps 0x00..0x99 over 99 edges; on the 100th edge Q=0x00 and rollover=1 for one cycle.
  - digit_tc[0]=1 at 0x10, 0x20, ... 0x90, and at 0x00 after the wrap.
- Same config, Load with LoadVal=0x00, then Up=0, En=1: next edge gives Q=0x99, rollover=1, digit_tc=2'b11; the following edge gives Q=0x98, rollover=0.
- Load LoadVal=0x5F: Q=0x59 (digit clamped). Then 3 up-counts give Q=0x60, 0x61, 0x62, with digit_tc[0]=1 only at 0x60.
- Counting at Q=0x37, assert Clear and Load together: next edge gives Q=0x00. Then En=0 for 5 edges: Q stays 0x00, rollover=0.
- Mid-count at Q=0x42, drop Reset_n between edges: Q=0x00 immediately, before the next edge. Release Reset_n with En=1: the first edge gives 0x01.
- N=3, K=8, DIGITS=3, Up=1 from 0o777: one edge gives Q=0, rollover=1, digit_tc=3'b111, confirming the K=2**N wrap.
